// File: rtl/event_rx_decoder_if.sv
`default_nettype none
// event_rx_decoder_if -- event word input, decoded-event stream and group/status bundle.
// Revision 1.0

interface event_rx_decoder_if #(
   parameter int ROW_W    = 4,
   parameter int COL_W    = 4,
   parameter int POLARITY = 2,
   parameter int WIDTH    = ROW_W + COL_W + POLARITY,
   parameter int CNT_W    = 8
);
   logic [WIDTH-1:0] data_in_i;
   logic             data_valid_i;
   logic             grp_release_i;
   logic             evt_valid_o;
   logic             evt_ready_i;
   logic [ROW_W-1:0] evt_row_o;
   logic [COL_W-1:0] evt_col_o;
   logic             evt_pol_o;
   logic             evt_last_o;
   logic             grp_done_o;
   logic [CNT_W-1:0] grp_on_cnt_o;
   logic [CNT_W-1:0] grp_off_cnt_o;
   logic             overflow_o;
   logic [CNT_W-1:0] drop_cnt_o;
   logic [CNT_W-1:0] err_cnt_o;
   logic             clear_i;

   modport slave (
      input  data_in_i, data_valid_i, grp_release_i, evt_ready_i, clear_i,
      output evt_valid_o, evt_row_o, evt_col_o, evt_pol_o, evt_last_o,
      output grp_done_o, grp_on_cnt_o, grp_off_cnt_o, overflow_o, drop_cnt_o, err_cnt_o
   );

   modport master (
      output data_in_i, data_valid_i, grp_release_i, evt_ready_i, clear_i,
      input  evt_valid_o, evt_row_o, evt_col_o, evt_pol_o, evt_last_o,
      input  grp_done_o, grp_on_cnt_o, grp_off_cnt_o, overflow_o, drop_cnt_o, err_cnt_o
   );
endinterface

`default_nettype wire

// File: rtl/event_rx_decoder.sv
`default_nettype none
// event_rx_decoder -- decodes arbiter event words into a show-ahead FIFO and keeps
// per-group ON/OFF counts plus drop/error statistics. Revision 1.0

module event_rx_decoder #(
   parameter int ROW_W    = 4,
   parameter int COL_W    = 4,
   parameter int POLARITY = 2,
   parameter int WIDTH    = ROW_W + COL_W + POLARITY,
   parameter int DEPTH    = 8,
   parameter int CNT_W    = 8
) (
   input wire logic        clk_i,
   input wire logic        reset_i,
   event_rx_decoder_if.slave bus
);

   localparam int               AW       = $clog2(DEPTH);
   localparam logic [AW:0]      FULL_OCC = (AW+1)'(DEPTH);
   localparam logic [AW-1:0]    IDX_ONE  = AW'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   typedef struct packed {
      logic [ROW_W-1:0] row;
      logic [COL_W-1:0] col;
      logic             pol;
   } entry_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   // Input decode
   logic [ROW_W-1:0]    in_row;
   logic [COL_W-1:0]    in_col;
   logic [POLARITY-1:0] in_pol;
   logic                is_on;
   logic                is_off;
   logic                ev_ok;
   logic                ev_err;

   assign in_row = bus.data_in_i[WIDTH-1 -: ROW_W];
   assign in_col = bus.data_in_i[POLARITY +: COL_W];
   assign in_pol = bus.data_in_i[POLARITY-1:0];
   assign is_on  = (in_pol == POLARITY'(1));
   assign is_off = (in_pol == POLARITY'(2));
   assign ev_ok  = bus.data_valid_i & (is_on | is_off);
   assign ev_err = bus.data_valid_i & ~(is_on | is_off);

   // Group FSM
   state_t state;
   state_t state_nxt;
   logic   grp_close;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      grp_close = 1'b0;
      case (state)
         IDLE: begin
            if (ev_ok) begin
               state_nxt = ACTIVE;
            end
         end
         ACTIVE: begin
            if (bus.grp_release_i) begin
               grp_close = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Show-ahead FIFO; pointers carry one extra bit to tell full from empty
   entry_t            mem [DEPTH];
   logic [DEPTH-1:0]  last_q;
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic [AW:0]       occ;
   logic [AW-1:0]     wr_idx;
   logic [AW-1:0]     rd_idx;
   logic [AW-1:0]     newest_idx;
   logic              empty;
   logic              full;
   logic              pop;
   logic              push;
   logic              ev_drop;
   logic              tag_prev;

   assign occ        = wr_ptr - rd_ptr;
   assign wr_idx     = wr_ptr[AW-1:0];
   assign rd_idx     = rd_ptr[AW-1:0];
   assign newest_idx = wr_idx - IDX_ONE;
   assign empty      = (occ == '0);
   assign full       = (occ == FULL_OCC);
   assign pop        = ~empty & bus.evt_ready_i;
   assign push       = ev_ok & (~full | pop);
   assign ev_drop    = ev_ok & full & ~pop;
   // A closing group without a stored coincident event tags the newest queued entry
   assign tag_prev   = grp_close & ~push & ~empty;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_idx] <= '{row: in_row, col: in_col, pol: is_on};
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         last_q <= '0;
      end else if (push) begin
         last_q[wr_idx] <= grp_close;
      end else if (tag_prev) begin
         last_q[newest_idx] <= 1'b1;
      end
   end

   // Stale storage is masked so the outputs read zero whenever nothing is queued
   assign bus.evt_valid_o = ~empty;
   assign bus.evt_row_o   = empty ? '0   : mem[rd_idx].row;
   assign bus.evt_col_o   = empty ? '0   : mem[rd_idx].col;
   assign bus.evt_pol_o   = empty ? 1'b0 : mem[rd_idx].pol;
   assign bus.evt_last_o  = empty ? 1'b0 : last_q[rd_idx];

   // Group and status counters
   logic [CNT_W-1:0] run_on;
   logic [CNT_W-1:0] run_off;
   logic [CNT_W-1:0] on_nxt;
   logic [CNT_W-1:0] off_nxt;
   logic [CNT_W-1:0] grp_on;
   logic [CNT_W-1:0] grp_off;
   logic [CNT_W-1:0] drop_cnt;
   logic [CNT_W-1:0] err_cnt;
   logic             grp_done;
   logic             overflow;

   assign on_nxt  = (ev_ok & is_on)  ? sat_inc(run_on)  : run_on;
   assign off_nxt = (ev_ok & is_off) ? sat_inc(run_off) : run_off;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         run_on   <= '0;
         run_off  <= '0;
         grp_on   <= '0;
         grp_off  <= '0;
         grp_done <= 1'b0;
         overflow <= 1'b0;
         drop_cnt <= '0;
         err_cnt  <= '0;
      end else begin
         grp_done <= grp_close;
         if (grp_close) begin
            grp_on  <= on_nxt;
            grp_off <= off_nxt;
            run_on  <= '0;
            run_off <= '0;
         end else begin
            run_on  <= on_nxt;
            run_off <= off_nxt;
         end
         if (bus.clear_i) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
            err_cnt  <= '0;
         end else begin
            if (ev_drop) begin
               overflow <= 1'b1;
               drop_cnt <= sat_inc(drop_cnt);
            end
            if (ev_err) begin
               err_cnt <= sat_inc(err_cnt);
            end
         end
      end
   end

   assign bus.grp_done_o    = grp_done;
   assign bus.grp_on_cnt_o  = grp_on;
   assign bus.grp_off_cnt_o = grp_off;
   assign bus.overflow_o    = overflow;
   assign bus.drop_cnt_o    = drop_cnt;
   assign bus.err_cnt_o     = err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_event_rx_decoder.sv
`default_nettype none
// tb_event_rx_decoder -- scoreboard bench: directed scenarios plus random traffic against
// a queue-based reference model of the decoder. Revision 1.0

module tb_event_rx_decoder;

   localparam int DEPTH = 8;
   localparam int CMAX  = 255;

   logic clk_i   = 1'b0;
   logic reset_i = 1'b0;

   always #5 clk_i = ~clk_i;

   event_rx_decoder_if bus ();

   event_rx_decoder dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .bus     (bus)
   );

   typedef struct {
      int row;
      int col;
      bit pol;
      bit last;
   } ent_t;

   ent_t q[$];
   int   n_vec  = 0;
   int   n_fail = 0;
   int   n_pops = 0;

   // Reference model state
   bit   m_active;
   int   m_run_on, m_run_off;
   int   m_on, m_off, m_drop, m_err;
   bit   m_done, m_ovf;
   int   m_pol;
   bit   m_ok, m_bad, m_close, m_stored;
   ent_t m_e;
   logic [9:0] hd;

   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: FIFO contents as a queue, group counts as plain integers
   always @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         q.delete();
         m_active = 0; m_run_on = 0; m_run_off = 0;
         m_on = 0; m_off = 0; m_drop = 0; m_err = 0;
         m_done = 0; m_ovf = 0;
      end else begin
         m_pol    = int'(bus.data_in_i[1:0]);
         m_ok     = bus.data_valid_i && (m_pol == 1 || m_pol == 2);
         m_bad    = bus.data_valid_i && !m_ok;
         m_close  = m_active && bus.grp_release_i;
         m_stored = 0;
         m_done   = m_close;
         if (m_ok) begin
            if (m_pol == 1) m_run_on++; else m_run_off++;
            if (q.size() < DEPTH) begin
               m_e.row  = int'(bus.data_in_i[9:6]);
               m_e.col  = int'(bus.data_in_i[5:2]);
               m_e.pol  = (m_pol == 1);
               m_e.last = m_close;
               q.push_back(m_e);
               m_stored = 1;
            end
         end
         if (bus.clear_i) begin
            m_drop = 0; m_err = 0; m_ovf = 0;
         end else begin
            if (m_ok && !m_stored) begin
               m_drop = sat(m_drop + 1);
               m_ovf  = 1;
            end
            if (m_bad) m_err = sat(m_err + 1);
         end
         if (m_close) begin
            if (!m_stored && q.size() > 0) begin
               m_e = q[q.size()-1];
               m_e.last = 1;
               q[q.size()-1] = m_e;
            end
            m_on = sat(m_run_on);
            m_off = sat(m_run_off);
            m_run_on = 0; m_run_off = 0;
            m_active = 0;
         end else if (m_ok) begin
            m_active = 1;
         end
      end
   end

   // Monitor: compares whatever the DUT presents against the model, pops on handshake
   always @(negedge clk_i) begin
      if (reset_i) begin
         chk("evt_valid", 32'(bus.evt_valid_o), 32'(q.size() > 0));
         if (q.size() > 0) begin
            hd = {q[0].row[3:0], q[0].col[3:0], q[0].pol, q[0].last};
            chk("evt_head", 32'({bus.evt_row_o, bus.evt_col_o, bus.evt_pol_o, bus.evt_last_o}),
                32'(hd));
            if (bus.evt_ready_i) begin
               void'(q.pop_front());
               n_pops++;
            end
         end
         chk("grp_done", 32'(bus.grp_done_o), 32'(m_done));
         chk("grp_on",   32'(bus.grp_on_cnt_o), 32'(m_on));
         chk("grp_off",  32'(bus.grp_off_cnt_o), 32'(m_off));
         chk("overflow", 32'(bus.overflow_o), 32'(m_ovf));
         chk("drop_cnt", 32'(bus.drop_cnt_o), 32'(m_drop));
         chk("err_cnt",  32'(bus.err_cnt_o), 32'(m_err));
      end
   end

   task automatic drive(input bit v, input int row, input int col, input int pol,
                        input bit rel, input bit rdy, input bit clr);
      logic [3:0] r4;
      logic [3:0] c4;
      logic [1:0] p2;
      r4 = 4'(row);
      c4 = 4'(col);
      p2 = 2'(pol);
      bus.data_in_i     = {r4, c4, p2};
      bus.data_valid_i  = v;
      bus.grp_release_i = rel;
      bus.evt_ready_i   = rdy;
      bus.clear_i       = clr;
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, rdy, 0);
   endtask

   task automatic do_reset();
      reset_i = 1'b0;
      bus.data_in_i = '0; bus.data_valid_i = 0; bus.grp_release_i = 0;
      bus.evt_ready_i = 0; bus.clear_i = 0;
      repeat (2) @(posedge clk_i);
      #1;
      reset_i = 1'b1;
      n_pops = 0;
   endtask

   initial begin
      // Reset state and basic in-order delivery with one-cycle latency
      do_reset();
      chk("rst_valid", 32'(bus.evt_valid_o), 0);
      chk("rst_row",   32'(bus.evt_row_o), 0);
      chk("rst_on",    32'(bus.grp_on_cnt_o), 0);
      chk("rst_ovf",   32'(bus.overflow_o), 0);
      chk("rst_err",   32'(bus.err_cnt_o), 0);
      drive(1, 2, 5, 1, 0, 1, 0);
      chk("lat_valid", 32'(bus.evt_valid_o), 1);
      chk("lat_row",   32'(bus.evt_row_o), 2);
      chk("lat_col",   32'(bus.evt_col_o), 5);
      drive(1, 7, 1, 2, 0, 1, 0);
      chk("lat_pol0",  32'(bus.evt_pol_o), 0);
      drive(1, 15, 15, 1, 0, 1, 0);
      idle(3, 1);
      chk("basic_pops", 32'(n_pops), 3);

      // Overflow: ten events into an eight-deep FIFO with the consumer stalled
      do_reset();
      for (int i = 0; i < 10; i++) drive(1, i, 15 - i, 1 + (i % 2), 0, 0, 0);
      chk("ovf_flag", 32'(bus.overflow_o), 1);
      chk("ovf_drop", 32'(bus.drop_cnt_o), 2);
      idle(12, 1);
      chk("ovf_pops", 32'(n_pops), 8);

      // Full FIFO with simultaneous push and pop
      do_reset();
      for (int i = 0; i < 8; i++) drive(1, i, i, 1, 0, 0, 0);
      drive(1, 9, 9, 2, 0, 1, 0);
      chk("fullpp_drop", 32'(bus.drop_cnt_o), 0);
      chk("fullpp_ovf",  32'(bus.overflow_o), 0);
      idle(12, 1);
      chk("fullpp_pops", 32'(n_pops), 9);

      // Group close with a coincident third event
      do_reset();
      drive(1, 1, 1, 1, 0, 0, 0);
      drive(1, 2, 2, 1, 0, 0, 0);
      drive(1, 3, 3, 2, 1, 0, 0);
      chk("grp_pulse", 32'(bus.grp_done_o), 1);
      chk("grp_on2",   32'(bus.grp_on_cnt_o), 2);
      chk("grp_off1",  32'(bus.grp_off_cnt_o), 1);
      idle(1, 0);
      chk("grp_pulse_end", 32'(bus.grp_done_o), 0);
      idle(5, 1);

      // Release in IDLE is ignored; invalid polarity is counted and not stored
      do_reset();
      drive(0, 0, 0, 0, 1, 1, 0);
      chk("idle_rel", 32'(bus.grp_done_o), 0);
      drive(1, 4, 4, 3, 0, 1, 0);
      chk("bad_err",   32'(bus.err_cnt_o), 1);
      chk("bad_valid", 32'(bus.evt_valid_o), 0);

      // Reset with five entries queued and an open group
      do_reset();
      for (int i = 0; i < 5; i++) drive(1, i, i, 1, 0, 0, 0);
      #2 reset_i = 1'b0;
      #1;
      chk("arst_valid", 32'(bus.evt_valid_o), 0);
      chk("arst_err",   32'(bus.err_cnt_o), 0);
      @(posedge clk_i);
      #1 reset_i = 1'b1;
      drive(1, 6, 6, 1, 0, 1, 0);
      drive(0, 0, 0, 0, 1, 1, 0);
      chk("arst_grp_on", 32'(bus.grp_on_cnt_o), 1);

      // Saturation of group, drop and error counters; clear beats increment
      do_reset();
      for (int i = 0; i < 300; i++) drive(1, i, i, 1, (i == 299), 0, 0);
      chk("sat_grp_on", 32'(bus.grp_on_cnt_o), CMAX);
      chk("sat_drop",   32'(bus.drop_cnt_o), CMAX);
      for (int i = 0; i < 300; i++) drive(1, i, i, 0, 0, 0, 0);
      chk("sat_err", 32'(bus.err_cnt_o), CMAX);
      drive(1, 0, 0, 3, 0, 0, 1);
      chk("clr_err",  32'(bus.err_cnt_o), 0);
      chk("clr_drop", 32'(bus.drop_cnt_o), 0);
      idle(10, 1);

      // Random traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         int sel;
         int pol;
         sel = int'($urandom_range(0, 9));
         pol = (sel < 4) ? 1 : (sel < 8) ? 2 : ((sel == 8) ? 0 : 3);
         drive(($urandom % 10) < 6, int'($urandom % 16), int'($urandom % 16), pol,
               ($urandom % 8) == 0, ($urandom % 2) == 1, ($urandom % 40) == 0);
      end
      idle(12, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
